// File: rtl/store_rom_config_multi.sv
// Tracks MiSTer ioctl ROM downloads for SLOTS cartridge slots, keeps a descriptor per slot,
// and announces every descriptor change to the slot-configuration logic one slot at a time.

package MSX;
    typedef struct packed {
        logic        loaded;
        logic [4:0]  rom_mapper;
        logic [24:0] rom_size;
    } ioctl_rom_t;
endpackage

module store_rom_config_multi #(
    parameter int SLOTS      = 2,
    parameter int BASE_INDEX = 3,
    parameter int SLOT_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [15:0]       ioctl_index,
    input  logic [26:0]       ioctl_addr,
    input  logic [SLOTS-1:0]  rom_eject,
    input  logic              update_ack,
    output logic              update_request,
    output logic [SLOT_W-1:0] update_slot,
    output logic              load_error,
    output MSX::ioctl_rom_t   ioctl_rom [SLOTS]
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic              download_prev_reg;
    logic              armed_reg;
    logic              active_reg;
    logic [15:0]       idx_reg;
    logic [SLOTS-1:0]  pending_reg;
    logic [SLOTS-1:0]  pending_next;
    logic [0:0]        state_reg;
    logic [SLOT_W-1:0] update_slot_reg;
    logic              load_error_reg;

    logic              loaded_reg [SLOTS];
    logic [4:0]        mapper_reg [SLOTS];
    logic [24:0]       size_reg   [SLOTS];

    logic              start_evt;
    logic              end_evt;
    logic [24:0]       new_size;
    logic              size_zero;
    logic [4:0]        new_mapper;
    logic [SLOTS-1:0]  load_hit;
    logic [SLOTS-1:0]  err_hit;
    logic [SLOTS-1:0]  set_mask;
    logic [SLOTS-1:0]  clr_mask;
    logic [SLOT_W-1:0] first_slot;
    logic              unused_bits;

    // A rising edge only counts once download has been seen low since reset, so a
    // download already in flight when reset releases never gets captured.
    assign start_evt  = ioctl_download & ~download_prev_reg & armed_reg;
    assign end_evt    = ~ioctl_download & download_prev_reg & active_reg;
    assign new_size   = ioctl_addr[24:0];
    assign size_zero  = (new_size == 25'd0);
    assign new_mapper = idx_reg[15] ? idx_reg[10:6] : 5'd0;

    assign unused_bits = ^{idx_reg[14:11], ioctl_addr[26:25]};

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic slot_match;
            assign slot_match   = (idx_reg[5:0] == 6'(BASE_INDEX + gi));
            assign load_hit[gi] = end_evt & slot_match & ~size_zero;
            assign err_hit[gi]  = end_evt & slot_match & size_zero;
            assign set_mask[gi] = load_hit[gi] | rom_eject[gi];
            assign clr_mask[gi] = (state_reg == ST_REQ) & update_ack
                                  & (update_slot_reg == SLOT_W'(gi));
            assign ioctl_rom[gi] = '{loaded:     loaded_reg[gi],
                                     rom_mapper: mapper_reg[gi],
                                     rom_size:   size_reg[gi]};
        end
    endgenerate

    // A new event in the ack cycle must survive the clear, hence set after clear.
    assign pending_next = (pending_reg & ~clr_mask) | set_mask;

    always_comb begin
        first_slot = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                first_slot = SLOT_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            download_prev_reg <= 1'b0;
            armed_reg         <= 1'b0;
            active_reg        <= 1'b0;
            idx_reg           <= '0;
            load_error_reg    <= 1'b0;
        end else begin
            download_prev_reg <= ioctl_download;
            load_error_reg    <= |err_hit;
            if (!ioctl_download) begin
                armed_reg <= 1'b1;
            end
            if (start_evt) begin
                idx_reg    <= ioctl_index;
                active_reg <= 1'b1;
            end else if (end_evt) begin
                active_reg <= 1'b0;
            end
        end
    end

    // Eject is applied after the load so it wins on the loaded flag only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                loaded_reg[i] <= 1'b0;
                mapper_reg[i] <= '0;
                size_reg[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (load_hit[i]) begin
                    loaded_reg[i] <= 1'b1;
                    mapper_reg[i] <= new_mapper;
                    size_reg[i]   <= new_size;
                end
                if (rom_eject[i]) begin
                    loaded_reg[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg     <= '0;
            state_reg       <= ST_IDLE;
            update_slot_reg <= '0;
        end else begin
            pending_reg <= pending_next;
            case (state_reg)
                ST_IDLE: begin
                    if (|pending_reg) begin
                        update_slot_reg <= first_slot;
                        state_reg       <= ST_REQ;
                    end
                end
                default: begin
                    if (update_ack) begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign update_request = (state_reg == ST_REQ);
    assign update_slot    = update_slot_reg;
    assign load_error     = load_error_reg;

endmodule

// File: tb/tb_store_rom_config_multi.sv
// Directed bench for store_rom_config_multi: stimulus pushes expected request slots into a
// queue, a monitor pops one on every new request; descriptors are checked inline.

module tb_store_rom_config_multi;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ioctl_download = 1'b0;
    logic [15:0]     ioctl_index = '0;
    logic [26:0]     ioctl_addr = '0;
    logic [1:0]      rom_eject = '0;
    logic            update_ack = 1'b0;
    logic            update_request;
    logic [0:0]      update_slot;
    logic            load_error;
    MSX::ioctl_rom_t ioctl_rom [2];

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    store_rom_config_multi #(.SLOTS(2), .BASE_INDEX(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .rom_eject      (rom_eject),
        .update_ack     (update_ack),
        .update_request (update_request),
        .update_slot    (update_slot),
        .load_error     (load_error),
        .ioctl_rom      (ioctl_rom)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_slot(input int s, input logic l, input logic [4:0] m, input logic [24:0] sz);
        chk($sformatf("slot%0d_loaded", s), 32'(ioctl_rom[s].loaded), 32'(l));
        chk($sformatf("slot%0d_mapper", s), 32'(ioctl_rom[s].rom_mapper), 32'(m));
        chk($sformatf("slot%0d_size", s), 32'(ioctl_rom[s].rom_size), 32'(sz));
    endtask

    // Starts at a negedge, ends with download driven low at a negedge.
    task automatic download(input logic [15:0] idx, input logic [26:0] addr, input logic [15:0] mid_idx);
        ioctl_index    = idx;
        ioctl_addr     = '0;
        ioctl_download = 1'b1;
        cyc(2);
        ioctl_index = mid_idx;
        cyc(2);
        ioctl_addr = addr;
        cyc(1);
        ioctl_download = 1'b0;
    endtask

    task automatic ack_one();
        int n = 0;
        while (!update_request && n < 20) begin
            cyc(1);
            n++;
        end
        if (!update_request) chk("ack_wait_timeout", 32'(update_request), 32'd1);
        update_ack = 1'b1;
        cyc(1);
        update_ack = 1'b0;
    endtask

    // Monitor: every rising update_request must match the next queued slot.
    initial begin
        logic req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (update_request && !req_prev) begin
                $display("[TB] request slot %0d", update_slot);
                if (exp_q.size() == 0) begin
                    chk("unexpected_request", 32'd1, 32'd0);
                end else begin
                    chk("request_slot", 32'(update_slot), 32'(exp_q.pop_front()));
                end
            end
            req_prev = update_request;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        reset = 1'b0;
        cyc(1);
        // Reset state
        check_slot(0, 1'b0, 5'd0, 25'd0);
        check_slot(1, 1'b0, 5'd0, 25'd0);
        chk("rst_request", 32'(update_request), 32'd0);
        chk("rst_slot", 32'(update_slot), 32'd0);
        chk("rst_load_error", 32'(load_error), 32'd0);
        cyc(2);

        // Index 3 with mapper 5, size 0x8000
        exp_q.push_back(0);
        download(16'h8143, 27'h8000, 16'h8143);
        cyc(1);
        check_slot(0, 1'b1, 5'd5, 25'h8000);
        chk("t1_req_edge1", 32'(update_request), 32'd0);
        cyc(1);
        chk("t1_req_edge2", 32'(update_request), 32'd1);
        chk("t1_slot", 32'(update_slot), 32'd0);
        update_ack = 1'b1;
        cyc(1);
        update_ack = 1'b0;
        chk("t1_req_released", 32'(update_request), 32'd0);
        cyc(3);

        // Index 4 then index 3 back to back, no ack until both done
        exp_q.push_back(1);
        exp_q.push_back(0);
        download(16'h0004, 27'h4000, 16'h0004);
        cyc(1);
        download(16'h8083, 27'h2000, 16'h8083);
        cyc(1);
        check_slot(0, 1'b1, 5'd2, 25'h2000);
        check_slot(1, 1'b1, 5'd0, 25'h4000);
        chk("t2_first_req", 32'(update_request), 32'd1);
        chk("t2_first_slot", 32'(update_slot), 32'd1);
        update_ack = 1'b1;
        cyc(1);
        update_ack = 1'b0;
        chk("t2_idle_gap", 32'(update_request), 32'd0);
        cyc(1);
        chk("t2_second_req", 32'(update_request), 32'd1);
        chk("t2_second_slot", 32'(update_slot), 32'd0);
        ack_one();
        chk("t2_released", 32'(update_request), 32'd0);
        cyc(2);

        // Eject both slots at once
        exp_q.push_back(0);
        exp_q.push_back(1);
        rom_eject = 2'b11;
        cyc(1);
        rom_eject = 2'b00;
        check_slot(0, 1'b0, 5'd2, 25'h2000);
        check_slot(1, 1'b0, 5'd0, 25'h4000);
        ack_one();
        ack_one();
        cyc(2);

        // Zero-size download at index 3
        download(16'h8043, 27'h0, 16'h8043);
        cyc(1);
        chk("t4_load_error_pulse", 32'(load_error), 32'd1);
        check_slot(0, 1'b0, 5'd2, 25'h2000);
        cyc(1);
        chk("t4_load_error_end", 32'(load_error), 32'd0);
        cyc(3);
        chk("t4_no_request", 32'(update_request), 32'd0);

        // Index changes from 3 to 9 mid-download; latched mapper 9 is used
        exp_q.push_back(0);
        download(16'h8243, 27'h10000, 16'h0009);
        cyc(1);
        check_slot(0, 1'b1, 5'd9, 25'h10000);
        check_slot(1, 1'b0, 5'd0, 25'h4000);
        ack_one();
        cyc(2);

        // Address bits 26:25 dropped from size
        exp_q.push_back(1);
        download(16'h0004, 27'h6000100, 16'h0004);
        cyc(1);
        check_slot(1, 1'b1, 5'd0, 25'h100);
        ack_one();
        cyc(2);

        // Indices outside the window are ignored
        download(16'h8145, 27'h1234, 16'h8145);
        cyc(1);
        download(16'h0002, 27'h1234, 16'h0002);
        cyc(1);
        chk("t5_oow_load_error", 32'(load_error), 32'd0);
        cyc(3);
        chk("t5_oow_no_request", 32'(update_request), 32'd0);
        check_slot(0, 1'b1, 5'd9, 25'h10000);
        check_slot(1, 1'b1, 5'd0, 25'h100);

        // Reset mid-download, download later falls at index 3
        ioctl_index    = 16'h8003;
        ioctl_download = 1'b1;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(2);
        ioctl_addr = 27'h3000;
        cyc(1);
        ioctl_download = 1'b0;
        cyc(1);
        check_slot(0, 1'b0, 5'd0, 25'd0);
        check_slot(1, 1'b0, 5'd0, 25'd0);
        chk("t6_load_error", 32'(load_error), 32'd0);
        cyc(3);
        chk("t6_no_request", 32'(update_request), 32'd0);
        chk("t6_slot", 32'(update_slot), 32'd0);

        // Eject in the ack cycle of the same slot re-requests it
        exp_q.push_back(0);
        rom_eject = 2'b01;
        cyc(1);
        rom_eject = 2'b00;
        begin
            int n = 0;
            while (!update_request && n < 20) begin
                cyc(1);
                n++;
            end
        end
        chk("t7_first_req", 32'(update_request), 32'd1);
        exp_q.push_back(0);
        update_ack = 1'b1;
        rom_eject  = 2'b01;
        cyc(1);
        update_ack = 1'b0;
        rom_eject  = 2'b00;
        chk("t7_idle_gap", 32'(update_request), 32'd0);
        cyc(1);
        chk("t7_rerequest", 32'(update_request), 32'd1);
        chk("t7_rerequest_slot", 32'(update_slot), 32'd0);
        ack_one();
        cyc(3);
        chk("final_no_request", 32'(update_request), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_rom_config_multi.md
# store_rom_config_multi

Parametrised successor of the cartridge ROM download tracker. It watches the MiSTer ioctl download stream and keeps a `MSX::ioctl_rom_t` descriptor for each of `SLOTS` ROM slots: loaded flag, mapper and size. It handles per-slot eject and reports every descriptor change to the slot-configuration logic through a serialised request/acknowledge handshake that names the affected slot. It sits between the HPS ioctl interface and the slot/memory-map rebuild logic.

## Interface
Parameters:
- `SLOTS`, default 2: number of ROM slots; legal range 1–8.
- `BASE_INDEX`, default 3: `ioctl_index[5:0]` value of slot 0; slot i uses `BASE_INDEX+i`. `BASE_INDEX+SLOTS-1` must not exceed 63.
- `SLOT_W`, default `$clog2(SLOTS)` with a minimum of 1: width of the slot number.

Ports:
- `clk`  in  1  system clock. Everything is synchronous to its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ioctl_download`  in  1  high while a download is in progress.
- `ioctl_index`  in  16  download index. Bits [5:0] select the target; bit 15 means a mapper is specified; bits [10:6] carry the mapper.
- `ioctl_addr`  in  27  byte address. At the end of a download it equals the byte count.
- `rom_eject`  in  `SLOTS`  per-slot eject. Each bit is a single-cycle pulse.
- `update_ack`  in  1  the consumer has taken the current request.
- `update_request`  out  1  a descriptor change is pending for `update_slot`.
- `update_slot`  out  `SLOT_W`  slot that the current request refers to.
- `load_error`  out  1  one-cycle pulse when a matching download ends with size 0.
- `ioctl_rom`  out  `MSX::ioctl_rom_t [SLOTS]`  per-slot descriptors.

## Operation
- **Start capture.** On the rising edge of `ioctl_download` (sampled against the registered previous value), latch `ioctl_index` into `idx_q` and set `active`. Later changes to `ioctl_index` during the download are ignored.
- **End handling.** On the falling edge with `active` set:
  - Clear `active`.
  - If `idx_q[5:0]` equals `BASE_INDEX+i` for some i < `SLOTS`, process slot i:
    - If `ioctl_addr[24:0]` is nonzero: set `loaded`=1; set `rom_mapper` to `idx_q[10:6]` if `idx_q[15]` is set, otherwise 0; set `rom_size` to `ioctl_addr[24:0]`; set `pending[i]`.
    - If the size is zero: leave the descriptor unchanged, leave `pending` unchanged, and pulse `load_error`.
  - Indices outside the window are ignored entirely.
- **Eject.** When `rom_eject[i]` is high: clear `loaded`, keep `rom_mapper` and `rom_size`, and set `pending[i]`. Ejecting a slot that is already unloaded still sets `pending[i]`.
- **Eject and load-end together on the same slot.** Eject wins: `loaded` ends at 0, mapper and size take the new values, and `pending` is set. Events on different slots in the same cycle are all applied.
- **Handshake state machine**, two states:
  - IDLE: `update_request`=0. If `pending` is nonzero, load `update_slot` with the lowest-numbered set bit and go to REQ.
  - REQ: `update_request`=1 and `update_slot` is held stable. When `update_ack` is high, clear `pending[update_slot]` and go to IDLE.
  - If a new event for the same slot arrives in the ack cycle, the set wins: the pending bit stays 1 and the slot is re-requested later.
  - `update_ack` is ignored in IDLE.
- **Arithmetic.** `rom_size` takes the low 25 address bits with no saturation; bits 26:25 are dropped.

## Timing
- **Reset values.** `update_request`=0, `update_slot`=0, `load_error`=0, and for every slot `loaded`=0, `rom_mapper`=0, `rom_size`=0. Internally `pending`=0, `active`=0, `idx_q`=0, previous-download register=0, state IDLE.
- **Load latency.** Descriptor fields update at the first clock edge after the first cycle in which `ioctl_download` is sampled low. `load_error` pulses in that same cycle.
- **Eject latency.** `loaded` clears one edge after the `rom_eject` cycle.
- **Request latency.** `update_request` rises one edge after `pending` becomes nonzero, so two edges after the event.
- **Release.** `update_request` falls at the edge after the ack is sampled. The next request rises at least one cycle later, leaving one guaranteed idle cycle between requests.
- **Reset during a download.** `active` is cleared, so the following falling edge of `ioctl_download` is ignored and no slot is loaded.
- **Falling edge without a captured rising edge** (for example, download already high when reset releases): ignored.

## Test plan
- Index 3, bit 15=1, bits[10:6]=5, download ending at `ioctl_addr`=0x8000 → slot 0: loaded=1, mapper=5, size=0x8000. `update_request`=1 and `update_slot`=0 two edges after the end; they clear one edge after ack.
- Index 4 with bit 15=0, then index 3, back to back, no ack → slot 1 requested first. After ack, one idle cycle, then slot 0 requested.
- `rom_eject`=2'b11 in one cycle → both slots loaded=0, mapper and size kept. Requests come out for slot 0, then slot 1.
- Download at index 3 ending with addr=0 → `load_error` pulses once, descriptor unchanged, no request.
- Index changes from 3 to 9 mid-download → slot 0 loads with the latched mapper; no change elsewhere.
- `reset` pulsed mid-download, download later falls at index 3 → all outputs at reset values, no request. Separately: `rom_eject[0]` in the same cycle as the ack for slot 0 → slot 0 is re-requested.
